apb_regbank_slave: RTL and testbench
====================================

// Module: apb_regbank_slave
// PURPOSE
//  Parametrised APB4 slave register bank with programmable wait states, byte strobes and
//  error signalling. Holds NUM_RW writable control registers and exposes NUM_RO read-only
//  status inputs. Sits behind the APB bus interface and is the standard CSR endpoint for
//  peripheral blocks.
// PARAMETERS
//  DATA_WIDTH   32  bus/register width; legal values 8, 16, 32, 64
//  ADDR_WIDTH   8   paddr width (byte address)
//  NUM_RW       4   number of read/write registers, at word indices 0..NUM_RW-1
//  NUM_RO       2   number of read-only registers, at word indices NUM_RW..NUM_RW+NUM_RO-1
//  WAIT_STATES  2   pready-low cycles inserted in ACCESS before completion; 0..15
//  RESET_VAL    0   reset value of every RW register (DATA_WIDTH bits)
// PORTS
//  pclk        in   1                    bus clock; all state on posedge
//  preset      in   1                    reset, asynchronous, active-high
//  paddr       in   ADDR_WIDTH           byte address
//  pselx       in   1                    slave select
//  penable     in   1                    access phase
//  pwrite      in   1                    1 = write, 0 = read
//  pwdata      in   DATA_WIDTH           write data
//  pstrb       in   DATA_WIDTH/8         write byte strobes
//  prdata      out  DATA_WIDTH           read data
//  pready      out  1                    transfer complete
//  pslverr     out  1                    transfer error; valid only with pready
//  rw_regs_o   out  NUM_RW*DATA_WIDTH    flattened RW registers; reg i at [i*DW +: DW]
//  ro_regs_i   in   NUM_RO*DATA_WIDTH    flattened RO status values; sampled on read
//  wr_pulse_o  out  NUM_RW               1-cycle pulse per RW register written
// BEHAVIOUR
//  Reset (async, preset=1)
//   - FSM goes to IDLE; wait counter = 0.
//   - Every RW register = RESET_VAL.
//   - pready, pslverr, wr_pulse_o = 0; prdata = 0.
//   - Outputs go low immediately, not on the next clock edge.
//  FSM states: IDLE, ACCESS
//   - IDLE: on pselx & !penable (setup cycle), latch paddr, pwrite, pwdata and pstrb.
//     Load cnt = WAIT_STATES and go to ACCESS.
//   - ACCESS: while pselx & penable & cnt != 0, decrement cnt each cycle.
//   - ACCESS: pready = (cnt == 0), combinational from state and cnt.
//   - ACCESS: commit happens on the edge where pselx & penable & pready. FSM then returns to IDLE.
//   - ACCESS: if pselx drops before completion, abort. Go to IDLE with no write and no error.
//   - Latency: setup cycle + WAIT_STATES + 1 access cycles (2 cycles when WAIT_STATES = 0).
//   - Back-to-back transfers: the cycle after completion may be the next setup cycle.
//     IDLE accepts it with no idle gap.
//  Decode
//   - LSB = log2(DATA_WIDTH/8); word index idx = paddr[ADDR_WIDTH-1:LSB].
//   - Error when paddr[LSB-1:0] != 0 (unaligned).
//   - Error when idx >= NUM_RW + NUM_RO (unmapped).
//   - Error on a write with idx >= NUM_RW (write to RO).
//  Error response
//   - pslverr = 1 together with pready.
//   - Registers unchanged, no wr_pulse, prdata = 0.
//  Write commit
//   - Byte lane b of reg[idx] is updated only when pstrb[b] = 1.
//   - pstrb == 0 gives no change, no pulse and no error.
//   - wr_pulse_o[idx] is high in the cycle after the commit edge, for exactly 1 cycle.
//  Read
//   - prdata = reg[idx], or ro_regs_i word (idx - NUM_RW), when pready & !pwrite & !error.
//   - Otherwise prdata = 0. pstrb is ignored on reads.
//  Outside ACCESS: pready = 0 and pslverr = 0. penable without a prior setup cycle is ignored.
//  Elaboration checks
//   - $error if DATA_WIDTH is not one of 8/16/32/64.
//   - $error if NUM_RW + NUM_RO > 2**(ADDR_WIDTH-LSB).
// STRUCTURE
//  - apb_pkg: apb_state_e {IDLE, ACCESS}; apb_err_e {OK, UNALIGNED, UNMAPPED, RO_WRITE};
//    function strb_merge(old, new, strb).
//  - Sub-module apb_addr_decoder: combinational; paddr/pwrite -> idx, is_ro, err (apb_err_e).
//  - Top holds the FSM, wait counter, latched request, register array and read mux.
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=8, NUM_RW=4, NUM_RO=2, WAIT_STATES=2 unless noted)
//  1. Write 0xDEADBEEF to 0x04, pstrb=4'hF.
//     -> pready=1 3 cycles after setup; pslverr=0; reg1=0xDEADBEEF; wr_pulse_o=4'b0010 for 1 cycle.
//     Then read 0x04 -> prdata=0xDEADBEEF.
//  2. With reg1=0xDEADBEEF, write 0x11223344, pstrb=4'b0101.
//     -> reg1=0xDE22BE44. Write with pstrb=0 -> unchanged, no pulse.
//  3. ro_regs_i word0=0xA5A50001; read 0x10 -> 0xA5A50001, pslverr=0.
//     Write 0x10 -> pslverr=1, no pulse, read-back unchanged.
//  4. Read 0x18 (idx 6) -> pslverr=1, prdata=0.
//     Write 0x05 (unaligned) -> pslverr=1, reg1 unchanged.
//  5. Abort and reset:
//     - pselx=0 during the 2nd wait cycle -> no write, next write to 0x00 completes normally.
//     - preset=1 mid-wait -> pready=0 immediately; all RW regs = RESET_VAL after release.
//  6. WAIT_STATES=0: consecutive writes to 0x00 and 0x08 with no idle cycle.
//     -> each completes in 2 cycles; wr_pulse_o = 4'b0001 then 4'b0100 on successive completions.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register bank: FSM states, decode errors, strobe merge.
// Combinational helpers only; no latency or flow control of their own.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    typedef enum logic [1:0] {OK, UNALIGNED, UNMAPPED, RO_WRITE} apb_err_e;

    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    // Sized for the widest legal bus; callers zero-extend and truncate.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_v,
        input logic [MAX_DW-1:0] new_v,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] res;
        res = old_v;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address and direction to a word index and an error class.
// Purely combinational; no latency and no backpressure.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 2,
    parameter int LSB        = 2,
    parameter int IDXW       = ADDR_WIDTH - LSB
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  pwrite_i,
    output logic [IDXW-1:0]       idx_o,
    output logic                  is_ro_o,
    output apb_err_e              err_o
);

    logic misaligned;

    generate
        if (LSB > 0) begin : g_lsb
            assign misaligned = |paddr_i[LSB-1:0];
        end else begin : g_no_lsb
            assign misaligned = 1'b0;
        end
    endgenerate

    assign idx_o   = paddr_i[ADDR_WIDTH-1:LSB];
    assign is_ro_o = 32'(idx_o) >= 32'(NUM_RW);

    // Priority: alignment first, then map range, then direction.
    always_comb begin
        err_o = OK;
        if (misaligned) begin
            err_o = UNALIGNED;
        end else if (32'(idx_o) >= 32'(NUM_RW + NUM_RO)) begin
            err_o = UNMAPPED;
        end else if (pwrite_i && is_ro_o) begin
            err_o = RO_WRITE;
        end
    end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 CSR bank: NUM_RW byte-strobed control regs plus NUM_RO status words, with error response.
// Latency setup + WAIT_STATES + 1 access cycles; waits via pready, aborts if pselx drops mid-access.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_RW      = 4,
    parameter int                    NUM_RO      = 2,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pselx,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_RW*DATA_WIDTH-1:0]   rw_regs_o,
    input  logic [NUM_RO*DATA_WIDTH-1:0]   ro_regs_i,
    output logic [NUM_RW-1:0]              wr_pulse_o
);

    localparam int SW   = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(SW);
    localparam int IDXW = ADDR_WIDTH - LSB;

    generate
        if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
            $error("apb_regbank_slave: DATA_WIDTH must be 8, 16, 32 or 64");
        end
        if (NUM_RW + NUM_RO > 2**IDXW) begin : g_bad_map
            $error("apb_regbank_slave: NUM_RW + NUM_RO exceeds the addressable word count");
        end
    endgenerate

    apb_state_e              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [SW-1:0]           pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_RW];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_RW];
    logic [NUM_RW-1:0]       wr_pulse_q, wr_pulse_d;

    logic [IDXW-1:0]         idx;
    logic                    is_ro;
    apb_err_e                err;
    logic                    commit;
    logic                    wr_commit;
    logic                    rd_ok;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO),
        .LSB        (LSB),
        .IDXW       (IDXW)
    ) u_dec (
        .paddr_i  (paddr_q),
        .pwrite_i (pwrite_q),
        .idx_o    (idx),
        .is_ro_o  (is_ro),
        .err_o    (err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pselx && !penable) begin
                    state_d  = ACCESS;
                    cnt_d    = 4'(WAIT_STATES);
                    paddr_d  = paddr;
                    pwrite_d = pwrite;
                    pwdata_d = pwdata;
                    pstrb_d  = pstrb;
                end
            end
            ACCESS: begin
                pready = (cnt_q == 4'd0);
                if (!pselx) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit    = pready && pselx && penable;
    assign pslverr   = pready && (err != OK);
    assign wr_commit = commit && pwrite_q && (err == OK) && (pstrb_q != '0);
    assign rd_ok     = pready && !pwrite_q && (err == OK);

    always_comb begin
        logic [MAX_DW-1:0] merged;
        merged     = '0;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_commit && idx == IDXW'(i)) begin
                merged     = strb_merge(MAX_DW'(regs_q[i]), MAX_DW'(pwdata_q), MAX_SW'(pstrb_q));
                regs_d[i]  = merged[DATA_WIDTH-1:0];
                wr_pulse_d[i] = 1'b1;
            end
        end
    end

    // Status words are sampled live so a read returns the value present at completion.
    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            if (is_ro) begin
                for (int j = 0; j < NUM_RO; j++) begin
                    if (idx == IDXW'(NUM_RW + j)) begin
                        prdata = ro_regs_i[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (idx == IDXW'(i)) begin
                        prdata = regs_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
            assign rw_regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    endgenerate

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: instance A has two wait states, instance B none with a nonzero reset value.
module tb_apb_regbank_slave;

    localparam logic [31:0] RST_B = 32'hC0DE_0000;

    logic         pclk = 1'b0;
    logic         preset;
    logic [7:0]   paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         sel_b;
    logic [63:0]  ro_regs;

    logic [31:0]  prdata_a, prdata_b;
    logic         pready_a, pready_b, pslverr_a, pslverr_b;
    logic [127:0] rw_a, rw_b;
    logic [3:0]   pulse_a, pulse_b;

    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [3:0]   pulse;

    assign prdata  = sel_b ? prdata_b  : prdata_a;
    assign pready  = sel_b ? pready_b  : pready_a;
    assign pslverr = sel_b ? pslverr_b : pslverr_a;
    assign pulse   = sel_b ? pulse_b   : pulse_a;

    always #5 pclk = ~pclk;

    apb_regbank_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_RW(4), .NUM_RO(2),
        .WAIT_STATES(2), .RESET_VAL(32'h0)
    ) u_dut_a (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(psel && !sel_b),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
        .rw_regs_o(rw_a), .ro_regs_i(ro_regs), .wr_pulse_o(pulse_a)
    );

    apb_regbank_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_RW(4), .NUM_RO(2),
        .WAIT_STATES(0), .RESET_VAL(RST_B)
    ) u_dut_b (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(psel && sel_b),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
        .rw_regs_o(rw_b), .ro_regs_i(ro_regs), .wr_pulse_o(pulse_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  pulse;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [2][4];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl[0][i] = 32'h0;
            mdl[1][i] = RST_B;
        end
    endtask

    // Entered and left on a negedge; the caller may start the next transfer with no gap.
    task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        exp_t got_e;
        int   idx;
        int   lat;
        logic bad;
        idx     = int'(addr >> 2);
        bad     = (addr[1:0] != 2'b00) || (idx >= 6) || (wr && idx >= 4);
        e.tag   = tag;
        e.err   = bad;
        e.rdata = 32'h0;
        e.pulse = 4'h0;
        e.lat   = sel_b ? 1 : 3;
        if (!wr && !bad) begin
            e.rdata = (idx < 4) ? mdl[sel_b][idx] : ro_regs[(idx-4)*32 +: 32];
        end
        if (wr && !bad && st != 4'h0) begin
            e.pulse = 4'(1 << idx);
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mdl[sel_b][idx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        sb_q.push_back(e);

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge pclk);
        penable = 1'b1;
        lat = 1;
        check({tag, "/pulse_clr"}, 64'(pulse), 64'h0);
        while (!pready && lat < 40) begin
            @(negedge pclk);
            lat++;
        end
        got_e = sb_q.pop_front();
        check({got_e.tag, "/pready"}, 64'(pready), 64'h1);
        check({got_e.tag, "/latency"}, 64'(lat), 64'(got_e.lat));
        check({got_e.tag, "/pslverr"}, 64'(pslverr), 64'(got_e.err));
        check({got_e.tag, "/prdata"}, 64'(prdata), 64'(got_e.rdata));
        @(negedge pclk);
        check({got_e.tag, "/wr_pulse"}, 64'(pulse), 64'(got_e.pulse));
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; sel_b = 1'b0;
        ro_regs = {32'h5A5A_0002, 32'hA5A5_0001};
        model_reset();

        #1;
        check("rst/pready", 64'(pready_a), 64'h0);
        check("rst/pslverr", 64'(pslverr_a), 64'h0);
        check("rst/prdata", 64'(prdata_a), 64'h0);
        check("rst/pulse", 64'(pulse_a), 64'h0);
        check("rst/rw_a_lo", rw_a[63:0], 64'h0);
        check("rst/rw_b_hi", rw_b[127:64], {RST_B, RST_B});
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // Full write, then read back
        apb_xfer("t1_wr", 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF);
        check("t1/reg1", 64'(rw_a[63:32]), 64'hDEAD_BEEF);
        apb_xfer("t1_rd", 1'b0, 8'h04, 32'h0, 4'hF);

        // Byte strobes, then an all-zero strobe
        apb_xfer("t2_strb", 1'b1, 8'h04, 32'h1122_3344, 4'b0101);
        check("t2/reg1_merge", 64'(rw_a[63:32]), 64'hDE22_BE44);
        apb_xfer("t2_nostrb", 1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0);
        check("t2/reg1_keep", 64'(rw_a[63:32]), 64'hDE22_BE44);

        // Status words and RO-write protection
        apb_xfer("t3_rd_ro0", 1'b0, 8'h10, 32'h0, 4'h0);
        apb_xfer("t3_wr_ro0", 1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF);
        apb_xfer("t3_rd_ro0b", 1'b0, 8'h10, 32'h0, 4'h0);
        apb_xfer("t3_rd_ro1", 1'b0, 8'h14, 32'h0, 4'h0);

        // Unmapped and unaligned
        apb_xfer("t4_unmapped", 1'b0, 8'h18, 32'h0, 4'h0);
        apb_xfer("t4_unaligned", 1'b1, 8'h05, 32'h0000_0000, 4'hF);
        check("t4/reg1_keep", 64'(rw_a[63:32]), 64'hDE22_BE44);

        // penable with no setup cycle must not start a transfer
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check("t4/no_setup_pready", 64'(pready), 64'h0);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("t4/no_setup_pulse", 64'(pulse), 64'h0);

        // Abort during the second wait cycle
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("t5/abort_pready", 64'(pready), 64'h0);
        check("t5/abort_pulse", 64'(pulse), 64'h0);
        check("t5/abort_reg0", 64'(rw_a[31:0]), 64'h0);
        apb_xfer("t5_after_abort", 1'b1, 8'h00, 32'h0000_0077, 4'hF);
        check("t5/reg0", 64'(rw_a[31:0]), 64'h77);

        // Reset while pready is high: must drop without waiting for a clock
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h9999_9999; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        check("t5/pre_rst_pready", 64'(pready), 64'h1);
        preset = 1'b1;
        #1;
        check("t5/rst_pready", 64'(pready), 64'h0);
        check("t5/rst_pslverr", 64'(pslverr), 64'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        model_reset();
        @(negedge pclk);
        check("t5/rst_rw_a", rw_a, 128'h0);
        check("t5/rst_rw_b_lo", rw_b[63:0], {RST_B, RST_B});
        check("t5/rst_pulse", 64'(pulse), 64'h0);

        // Zero wait states, back-to-back writes
        sel_b = 1'b1;
        @(negedge pclk);
        apb_xfer("t6_wr0", 1'b1, 8'h00, 32'h1234_5678, 4'hF);
        apb_xfer("t6_wr2", 1'b1, 8'h08, 32'hCAFE_F00D, 4'hF);
        check("t6/reg0", 64'(rw_b[31:0]), 64'h1234_5678);
        check("t6/reg2", 64'(rw_b[95:64]), 64'hCAFE_F00D);
        check("t6/reg1_rst", 64'(rw_b[63:32]), 64'(RST_B));
        apb_xfer("t6_rd2", 1'b0, 8'h08, 32'h0, 4'h0);
        apb_xfer("t6_rd1", 1'b0, 8'h04, 32'h0, 4'h0);

        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
